// File: rtl/load_unit.sv
// MEM-stage load unit: decodes load ops, issues one SRAM-like read, then extracts and extends the result.
// Optional LOAD_ALIGN_CHECK_EN: misaligned LH/LHU/LW raise adelM without issuing a bus request.
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b1110_0000
`endif
`ifndef EXE_LBU_OP
`define EXE_LBU_OP 8'b1110_0100
`endif
`ifndef EXE_LH_OP
`define EXE_LH_OP  8'b1110_0001
`endif
`ifndef EXE_LHU_OP
`define EXE_LHU_OP 8'b1110_0101
`endif
`ifndef EXE_LW_OP
`define EXE_LW_OP  8'b1110_0011
`endif

module load_unit #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ld_valid,
    input  logic [7:0]    alucontrolM,
    input  logic [AW-1:0] addrM,
    input  logic          flush,
    output logic          ld_ready,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [31:0]   data_rdata,
    output logic          res_valid,
    output logic [31:0]   res_data,
    output logic          adelM,
    input  logic          res_ready,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, DONE} state_t;
    typedef struct packed {
        logic [1:0]    size;
        logic          sext;
        logic [AW-1:0] addr;
    } ld_req_t;

    state_t        state, state_nx;
    ld_req_t       cap;
    logic          is_load, cap_en, res_en, misalign;
    logic [1:0]    dec_size;
    logic          dec_sext;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ext, res_q;
    logic [AW-1:0] req_addr;

    always_comb begin
        is_load  = 1'b1;
        dec_size = 2'd0;
        dec_sext = 1'b0;
        case (alucontrolM)
            `EXE_LB_OP:  dec_sext = 1'b1;
            `EXE_LBU_OP: dec_sext = 1'b0;
            `EXE_LH_OP:  begin dec_size = 2'd1; dec_sext = 1'b1; end
            `EXE_LHU_OP: dec_size = 2'd1;
            `EXE_LW_OP:  dec_size = 2'd2;
            default:     is_load = 1'b0;
        endcase
    end

`ifdef LOAD_ALIGN_CHECK_EN
    logic adel_q;
    assign misalign = (dec_size == 2'd1 && addrM[0]) ||
                      (dec_size == 2'd2 && addrM[1:0] != 2'b00);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     adel_q <= 1'b0;
        else if (cap_en) adel_q <= misalign;
    end
    assign adelM = adel_q;
`else
    assign misalign = 1'b0;
    assign adelM    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cap_en   = 1'b0;
        res_en   = 1'b0;
        case (state)
            IDLE: if (ld_valid && is_load && !flush) begin
                cap_en   = 1'b1;
                state_nx = misalign ? DONE : REQ;
            end
            REQ: begin
                if (data_addr_ok) state_nx = flush ? DROP : WAIT;
                else if (flush)   state_nx = IDLE;
            end
            // A flush that lands on the response itself has nothing left to drain.
            WAIT: begin
                if (flush) state_nx = data_data_ok ? IDLE : DROP;
                else if (data_data_ok) begin
                    res_en   = 1'b1;
                    state_nx = DONE;
                end
            end
            DROP: if (data_data_ok) state_nx = IDLE;
            DONE: if (flush || res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // res_q is cleared on capture so an address-error result reads as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cap   <= '0;
            res_q <= '0;
        end else begin
            state <= state_nx;
            if (cap_en) begin
                cap   <= {dec_size, dec_sext, addrM};
                res_q <= '0;
            end
            if (res_en) res_q <= ext;
        end
    end

    always_comb begin
        byte_v = data_rdata[{cap.addr[1:0], 3'b000} +: 8];
        half_v = cap.addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (cap.size)
            2'd0:    ext = {{24{cap.sext & byte_v[7]}}, byte_v};
            2'd1:    ext = {{16{cap.sext & half_v[15]}}, half_v};
            default: ext = data_rdata;
        endcase
    end

    always_comb begin
        req_addr = cap.addr;
        if (cap.size == 2'd2)      req_addr[1:0] = 2'b00;
        else if (cap.size == 2'd1) req_addr[0]   = 1'b0;
    end

    assign ld_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign data_req  = (state == REQ);
    assign data_wr   = 1'b0;
    assign data_size = data_req ? cap.size : 2'd0;
    assign data_addr = data_req ? req_addr : '0;
    assign res_valid = (state == DONE);
    assign res_data  = res_q;
endmodule

// File: tb/tb_load_unit.sv
// Randomized scoreboard bench for load_unit: the driver also plays the bus and pushes expected results.
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b1110_0000
`endif
`ifndef EXE_LBU_OP
`define EXE_LBU_OP 8'b1110_0100
`endif
`ifndef EXE_LH_OP
`define EXE_LH_OP  8'b1110_0001
`endif
`ifndef EXE_LHU_OP
`define EXE_LHU_OP 8'b1110_0101
`endif
`ifndef EXE_LW_OP
`define EXE_LW_OP  8'b1110_0011
`endif

module tb_load_unit;
    localparam int AW = 32;

    logic          clk = 1'b0, resetn = 1'b0;
    logic          ld_valid = 1'b0, flush = 1'b0;
    logic [7:0]    alucontrolM = 8'h00;
    logic [AW-1:0] addrM = '0;
    logic          ld_ready, data_req, data_wr, res_valid, adelM, busy;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic          data_addr_ok = 1'b0, data_data_ok = 1'b0, res_ready = 1'b0;
    logic [31:0]   data_rdata = '0, res_data;

    load_unit #(.AW(AW)) dut (
        .clk(clk), .resetn(resetn), .ld_valid(ld_valid), .alucontrolM(alucontrolM),
        .addrM(addrM), .flush(flush), .ld_ready(ld_ready), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .res_valid(res_valid), .res_data(res_data), .adelM(adelM),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic adel; } exp_t;
    exp_t sb[$];
    int vectors = 0, miscompares = 0;
    logic [7:0] ops [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Reference: pick the addressed lane with shifts/modulo, extend with plain arithmetic.
    function automatic logic [31:0] model(input logic [7:0] op, input int unsigned addr,
                                          input int unsigned rd);
        int unsigned b, h;
        b = (rd >> (8 * (addr % 4))) % 256;
        h = (rd >> (16 * ((addr / 2) % 2))) % 65536;
        case (op)
            `EXE_LB_OP:  return (b < 128)   ? b : b + 32'hFFFF_FF00;
            `EXE_LBU_OP: return b;
            `EXE_LH_OP:  return (h < 32768) ? h : h + 32'hFFFF_0000;
            `EXE_LHU_OP: return h;
            default:     return rd;
        endcase
    endfunction

    // Monitor: every presented result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (resetn && res_valid && !flush) begin
            if (sb.size() == 0) check("unexpected_res_valid", 1, 0);
            else begin
                check("res_data", res_data, sb[0].data);
                check("adelM", {31'b0, adelM}, {31'b0, sb[0].adel});
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic done_phase(input int rr, input bit fl3);
        if (fl3) begin
            flush = 1'b1;
            at_neg(); check("done_res_valid", {31'b0, res_valid}, 1);
            step(); flush = 1'b0;
            at_neg(); check("flush_done_idle", {30'b0, busy, res_valid}, 0);
            return;
        end
        for (int i = 0; i <= rr; i++) begin
            res_ready = (i == rr);
            at_neg(); check("done_res_valid", {31'b0, res_valid}, 1);
            step();
        end
        res_ready = 1'b0;
        at_neg(); check("post_done_idle", {30'b0, ld_ready, busy}, 32'd2);
    endtask

    // fl: 0 none, 1 flush in REQ before addr_ok, 2 flush in WAIT, 3 flush in DONE, 4 flush with addr_ok
    task automatic do_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rd,
                           input int aok, input int dok, input int rr, input int fl);
        int unsigned sz, gran;
        bit mis, err, drop;
        logic [31:0] exp_addr;
        sz   = (op == `EXE_LW_OP) ? 2 : (op == `EXE_LH_OP || op == `EXE_LHU_OP) ? 1 : 0;
        gran = 1 << sz;
        mis  = (addr % gran) != 0;
        err  = 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
        err = mis;
`endif
        exp_addr = addr - (addr % gran);
        step();
        ld_valid = 1'b1; alucontrolM = op; addrM = addr;
        step();
        ld_valid = 1'b0; alucontrolM = 8'($urandom); addrM = $urandom;
        if (err) begin
            if (fl != 3) sb.push_back('{32'h0, 1'b1});
            check("ae_no_req", {31'b0, data_req}, 0);
            done_phase(rr, fl == 3);
            return;
        end
        if (fl == 1) begin
            flush = 1'b1;
            at_neg(); check("req_before_flush", {31'b0, data_req}, 1);
            step(); flush = 1'b0;
            at_neg(); check("flush_req_idle", {30'b0, busy, data_req}, 0);
            return;
        end
        drop = (fl == 2 || fl == 4);
        if (!drop && fl != 3) sb.push_back('{model(op, addr, rd), 1'b0});
        for (int i = 0; i <= aok; i++) begin
            data_addr_ok = (i == aok);
            if (i == aok && fl == 4) flush = 1'b1;
            at_neg();
            check("req_valid", {30'b0, data_req, data_wr}, 32'd2);
            check("req_size", {30'b0, data_size}, sz);
            check("req_addr", data_addr, exp_addr);
            step();
        end
        data_addr_ok = 1'b0; flush = 1'b0;
        if (fl == 2) flush = 1'b1;
        for (int i = 0; i <= dok; i++) begin
            data_data_ok = (i == dok);
            data_rdata   = (i == dok) ? rd : $urandom;
            at_neg();
            if (i == 0) check("req_dropped", {31'b0, data_req}, 0);
            check("wait_busy", {31'b0, busy}, 1);
            step();
            flush = 1'b0;
        end
        data_data_ok = 1'b0;
        if (drop) begin
            at_neg(); check("drop_idle", {30'b0, ld_ready, res_valid}, 32'd2);
            return;
        end
        done_phase(rr, fl == 3);
    endtask

    initial begin
        ops[0] = `EXE_LB_OP; ops[1] = `EXE_LBU_OP; ops[2] = `EXE_LH_OP;
        ops[3] = `EXE_LHU_OP; ops[4] = `EXE_LW_OP;
        #12;
        check("rst_req", {28'b0, data_req, data_wr, data_size}, 0);
        check("rst_addr", data_addr, 0);
        check("rst_res", {29'b0, res_valid, adelM, busy}, 0);
        check("rst_res_data", res_data, 0);
        step(); resetn = 1'b1;
        at_neg(); check("ld_ready_after_rst", {31'b0, ld_ready}, 1);

        // Directed cases from the worked examples.
        do_load(`EXE_LB_OP,  32'h1003, 32'h80FF_1234, 0, 0, 0, 0);
        do_load(`EXE_LHU_OP, 32'h1002, 32'h8765_4321, 3, 0, 0, 0);
        do_load(`EXE_LW_OP,  32'h2000, 32'hDEAD_BEEF, 0, 1, 5, 0);
        do_load(`EXE_LW_OP,  32'h2002, 32'hCAFE_F00D, 0, 0, 1, 0);
        do_load(`EXE_LW_OP,  32'h2004, 32'h1111_2222, 0, 2, 0, 2);
        do_load(`EXE_LH_OP,  32'h2006, 32'h8001_7FFF, 2, 0, 0, 1);
        do_load(`EXE_LH_OP,  32'h2006, 32'h8001_7FFF, 1, 1, 0, 4);
        do_load(`EXE_LBU_OP, 32'h2001, 32'h0000_8000, 0, 0, 2, 3);

        // Non-load op and flush-in-IDLE must not capture.
        step(); ld_valid = 1'b1; alucontrolM = 8'h21; addrM = 32'h40;
        step(); ld_valid = 1'b0;
        at_neg(); check("nonload_ignored", {31'b0, busy}, 0);
        step(); ld_valid = 1'b1; alucontrolM = `EXE_LW_OP; flush = 1'b1;
        step(); ld_valid = 1'b0; flush = 1'b0;
        at_neg(); check("flush_idle_blocks", {31'b0, busy}, 0);

        // Reset in REQ, then a stale response.
        step(); ld_valid = 1'b1; alucontrolM = `EXE_LW_OP; addrM = 32'h3000;
        step(); ld_valid = 1'b0;
        at_neg(); check("pre_rst_req", {31'b0, data_req}, 1);
        #1 resetn = 1'b0;
        #1 check("rst_mid_req", {30'b0, data_req, busy}, 0);
        step(); resetn = 1'b1;
        step(); data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        step(); data_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg(); check("stale_data_ok", {30'b0, res_valid, busy}, 0);
        end

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            int aok, dok, rr, fl;
            aok = $urandom_range(0, 3); dok = $urandom_range(0, 3);
            rr  = $urandom_range(0, 3); fl  = $urandom_range(0, 9);
            if (fl > 4) fl = 0;
            if (fl == 1 && aok == 0) aok = 1;
            if (fl == 2 && dok == 0) dok = 1;
            do_load(ops[$urandom_range(0, 4)], $urandom, $urandom, aok, dok, rr, fl);
            if ($urandom_range(0, 3) == 0) begin
                step(); data_data_ok = 1'b1; data_rdata = $urandom;
                step(); data_data_ok = 1'b0;
                at_neg(); check("idle_data_ok", {31'b0, busy}, 0);
            end
        end

        step();
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
